// File: rtl/chunk_mem_pkg.sv
// Shared types and constants for the chunk row store: row geometry, FSM states.
package chunk_mem_pkg;
  localparam int ROW_W   = 512;
  localparam int WORD_W  = 32;
  localparam int MIN_MSB = 31;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_MERGE} state_e;
  typedef logic [511:0] row_t;
endpackage

// File: rtl/chunk_row_store_if.sv
// Chunk buffer bus: active-low strobes from the mining controller, row data back.
interface chunk_row_store_if;
  import chunk_mem_pkg::*;

  logic              cs_n;
  logic              wr_n;
  logic              rd_n;
  logic [15:0]       addr;
  logic [8:0]        addr_width;
  logic [WORD_W-1:0] data_in;
  row_t              data_out;
  logic              data_valid;
  logic              busy;
  logic              oob_err;

  modport master (
    output cs_n, wr_n, rd_n, addr, addr_width, data_in,
    input  data_out, data_valid, busy, oob_err
  );

  modport slave (
    input  cs_n, wr_n, rd_n, addr, addr_width, data_in,
    output data_out, data_valid, busy, oob_err
  );
endinterface

// File: rtl/word_insert.sv
// Splices a 32-bit word into a row at bits [msb_i -: 32]; bits past 511 are dropped, never wrapped.
module word_insert
  import chunk_mem_pkg::*;
(
  input  row_t              row_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [8:0]        msb_i,
  output row_t              row_o
);
  logic [8:0] lsb;
  row_t       mask;
  row_t       ins;

  always_comb begin
    lsb   = (msb_i >= 9'(MIN_MSB)) ? (msb_i - 9'(MIN_MSB)) : '0;
    mask  = row_t'({WORD_W{1'b1}}) << lsb;
    ins   = row_t'(word_i) << lsb;
    row_o = (row_i & ~mask) | ins;
  end
endmodule

// File: rtl/chunk_row_store.sv
// Row store for the SHA-256 chunk buffer: 32-bit read-modify-write inserts, whole-row reads.
module chunk_row_store #(
  parameter int DEPTH          = 16,
  parameter int ROW_W          = 512,
  parameter int WORD_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic               clock,
  input logic               reset,
  chunk_row_store_if.slave  bus
);
  import chunk_mem_pkg::*;

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [ROW_W-1:0]  mem [DEPTH];

  state_e            state_q;
  logic [AW-1:0]     clr_cnt_q;
  logic [AW-1:0]     addr_q;
  logic [8:0]        msb_q;
  logic [WORD_W-1:0] word_q;
  logic [ROW_W-1:0]  row_q;
  logic [ROW_W-1:0]  data_out_q;
  logic              data_valid_q;
  logic              oob_err_q;
  row_t              merged;

  logic          req_sel, wr_req, rd_req, addr_ok, width_ok;
  logic          wr_go, rd_go, reject;
  logic [AW-1:0] addr_idx;

  // Request decode; only IDLE samples the strobes, so held strobes re-arm after MERGE/CLEAR
  always_comb begin
    addr_idx = bus.addr[AW-1:0];
    req_sel  = (state_q == ST_IDLE) && !bus.cs_n;
    wr_req   = req_sel && !bus.wr_n;
    rd_req   = req_sel && bus.wr_n && !bus.rd_n;
    addr_ok  = {1'b0, bus.addr} < DEPTH_L;
    width_ok = bus.addr_width >= 9'(MIN_MSB);
    wr_go    = wr_req && addr_ok && width_ok;
    rd_go    = rd_req && addr_ok;
    reject   = (wr_req && !(addr_ok && width_ok)) || (rd_req && !addr_ok);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      oob_err_q    <= 1'b0;
    end else begin
      data_valid_q <= rd_go;
      oob_err_q    <= reject;
      if (rd_go) data_out_q <= mem[addr_idx];
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == AW'(DEPTH - 1)) state_q <= ST_IDLE;
        end
        ST_IDLE:  if (wr_go) state_q <= ST_MERGE;
        ST_MERGE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Write request capture: first half of the read-modify-write
  always_ff @(posedge clock) begin
    if (wr_go) begin
      addr_q <= addr_idx;
      msb_q  <= bus.addr_width;
      word_q <= bus.data_in;
      row_q  <= mem[addr_idx];
    end
  end

  word_insert u_word_insert (
    .row_i  (row_q),
    .word_i (word_q),
    .msb_i  (msb_q),
    .row_o  (merged)
  );

  // Reset gates the write port so a MERGE interrupted by reset leaves the row untouched
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state_q == ST_CLEAR)      mem[clr_cnt_q] <= '0;
      else if (state_q == ST_MERGE) mem[addr_q]    <= merged;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.oob_err    = oob_err_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: doc/chunk_row_store.md
# chunk_row_store

Memory-side responder for the mining datapath's chunk buffer bus. Serves the active-low `cs_n`/`wr_n`/`rd_n` strobes issued by the mining controller. Writes insert one 32-bit word at a selectable bit position into a 512-bit row. Reads return a whole 512-bit row, which feeds the SHA-256 chunk input.

## Interface
- `DEPTH`, 16: number of 512-bit rows; legal addresses are 0..DEPTH-1.
- `ROW_W`, 512: row width in bits.
- `WORD_W`, 32: write word width in bits.
- `CLEAR_ON_RESET`, 1: when 1, reset zero-fills every row.

- `clock`  in  1  system clock; reset reset, synchronous, active-low; clock clock.
- `reset`  in  1  synchronous, active-low.
- `cs_n`  in  1  chip select, active low.
- `wr_n`  in  1  write strobe, active low, level-sampled.
- `rd_n`  in  1  read strobe, active low, level-sampled.
- `addr`  in  16  row address.
- `addr_width`  in  9  bit index of the MSB of the written word; the word lands in bits [addr_width : addr_width-31].
- `data_in`  in  32  write word.
- `data_out`  out  512  registered read row.
- `data_valid`  out  1  one-cycle pulse when `data_out` is updated.
- `busy`  out  1  request not accepted this cycle.
- `oob_err`  out  1  one-cycle pulse when an illegal request is rejected.

## Operation
- States:
  - CLEAR: zero-fill, one row per cycle.
  - IDLE: accept requests.
  - MERGE: read-modify-write, second cycle.
- Request decode happens in IDLE only, with `cs_n`=0:
  - `wr_n`=0 means write. Write has priority: if `rd_n`=0 in the same cycle, the read is dropped with no error.
  - `wr_n`=1 and `rd_n`=0 means read.
  - Otherwise no operation.
- Write:
  - IDLE cycle: latch `addr`, `addr_width`, `data_in`; read the row into a holding register; go to MERGE.
  - MERGE: replace bits [addr_width -: 32] of the held row with the latched word, write the row back, return to IDLE.
  - All other bits of the row are unchanged.
- Read: row[`addr`] is registered into `data_out` and `data_valid`=1 on the next cycle. `data_out` holds until the next read.
- Strobes are level-sensitive. A held-low `wr_n` repeats the write every 2 cycles, which is idempotent. A held-low `rd_n` re-reads every cycle.
- Rejection: `addr` ≥ DEPTH, or a write with `addr_width` < 31. Memory is untouched, `oob_err` pulses for one cycle, `data_valid` stays 0, state stays IDLE.
- Requests presented while `busy`=1 are ignored, not queued. The initiator's held strobes are re-sampled once the block returns to IDLE.
- A read presented in the cycle after MERGE returns the merged row. No bypass path is needed.

## Timing
- Reset (`reset`=0 at a clock edge):
  - Outputs: `data_out`=0, `data_valid`=0, `oob_err`=0.
  - State and `busy`:
    - `CLEAR_ON_RESET`=1: state=CLEAR, row counter=0, `busy`=1.
    - `CLEAR_ON_RESET`=0: state=IDLE, `busy`=0.
- CLEAR writes rows 0..DEPTH-1 on consecutive cycles, then goes to IDLE. `busy` drops on the first IDLE cycle, DEPTH cycles after reset is released.
- Reset asserted mid-MERGE aborts the write (the row keeps its old value) and restarts CLEAR.
- Write latency: 2 cycles. Request at cycle T, MERGE at T+1 with `busy`=1, new value readable from a request at T+2.
- Read latency: 1 cycle. Request at T gives `data_out` and `data_valid` at T+1. Maximum throughput is 1 read per cycle and 1 write per 2 cycles.
- `oob_err` asserts at T+1 for a rejected request at T.
- The `addr_width` slice uses a 9-bit index, so positions up to bit 511 are legal. No wrap-around of the word across the row boundary.

## Structure
- Package `chunk_mem_pkg`:
  - constants ROW_W=512, WORD_W=32, MIN_MSB=31;
  - state enum {ST_CLEAR, ST_IDLE, ST_MERGE};
  - row typedef `logic [511:0]`.
- Sub-module `word_insert` (combinational): inputs row[511:0], word[31:0], msb[8:0]; output is the row with the word spliced in.
- Storage is an inferred register/BRAM array in the top level.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, DEPTH=16:
  - `busy` stays high for 16 cycles.
  - Reading row 5 then returns 512'h0 with `data_valid` one cycle later.
- Write 32'hDEADBEEF to row 2 at `addr_width`=511, then 32'h00000001 at `addr_width`=31:
  - Reading row 2 gives bits [511:480]=DEADBEEF and [31:0]=00000001, with all other bits 0.
- `cs_n`=0, `wr_n`=0, `rd_n`=0, `addr`=3, word 32'h12345678 at `addr_width`=63:
  - No `data_valid`.
  - Row 3 bits [63:32]=12345678.
- Illegal requests:
  - Write with `addr`=16 gives an `oob_err` pulse and no row changes.
  - Write with `addr_width`=20 gives an `oob_err` pulse and no row changes.
- Hold `wr_n`=0 for 6 cycles with `data_in`=32'hA5A5A5A5 at row 0:
  - `busy` toggles 0,1,0,1,0,1.
  - Final row 0 contains the word once, at the selected slice.
- Reset asserted during MERGE of row 7:
  - Row 7 reads back 0 after CLEAR.
  - Outputs are 0 during reset.
